ic_fetch: RTL
=============

// Module: ic_fetch
// PURPOSE
//  Instruction-fetch stage; producer side of ic_to_id_bus / ic_inst consumed by the decode stage.
//  Owns the fetch PC, issues requests on the req/addr_ok/data_ok instruction-SRAM interface,
//  and packs {excepttype, ce, pc} plus the fetched word for decode.
//  Sits between the PC/branch/exception logic (br_e, flush) and the decode-stage register.
// PARAMETERS
//  RESET_PC     32'hBFC0_0000  first fetch address after reset
//  IC_TO_ID_WD  65             width of ic_to_id_bus = 32 excepttype + 1 ce + 32 pc
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  stall          in   6   `StallBus; stall[1]==`Stop holds this stage's output
//  flush          in   1   exception/eret flush; redirect to new_pc
//  new_pc         in   32  flush target
//  br_e           in   1   taken branch/jump resolved downstream
//  br_addr        in   32  branch target
//  stallreq       out  1   fetch not ready; requests pipeline stall
//  inst_req       out  1   instruction-bus request
//  inst_addr      out  32  request address, word aligned
//  inst_addr_ok   in   1   request accepted this cycle (when inst_req=1)
//  inst_data_ok   in   1   read data valid this cycle
//  inst_rdata     in   32  read data
//  ic_to_id_bus   out  65  {excepttype[31:0], ic_ce, ic_pc[31:0]}
//  ic_inst        out  32  fetched instruction, aligned with ic_to_id_bus
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, state=IDLE, inst_req=0, ic_ce=0, ic_pc=0, ic_inst=0,
//   excepttype=0, cancel_cnt=0, out_valid=0, stallreq=0.
//  FSM IDLE -> REQ (next cycle, unless stall[1]) ; REQ holds inst_req=1, inst_addr=fetch_pc
//   until inst_addr_ok -> WAIT ; WAIT until inst_data_ok -> IDLE (or REQ if output slot free).
//  On addr_ok: pend_pc<=fetch_pc; fetch_pc<=fetch_pc+4. At most one live outstanding request.
//  On data_ok with cancel_cnt==0: out slot <= {excepttype=0, ce=1, pend_pc, inst_rdata}.
//  Output slot is 1 entry: while stall[1]==`Stop, ic_to_id_bus/ic_inst hold steady; no new
//   data overwrites it; next REQ issues only once slot is consumed (stall[1]==`NoStop).
//  stallreq = (state!=IDLE || !out_valid) && !rst, i.e. decode would take a bubble.
//   When no valid word is presented, ic_ce=0 and ic_pc=0 (bubble).
//  Redirect priority: rst > flush > br_e > sequential. flush/br_e set fetch_pc to new_pc/br_addr,
//   invalidate out slot (ce=0 next cycle).
//  Redirect while in WAIT, or in REQ on the same cycle as addr_ok: cancel_cnt++; the matching
//   data_ok is consumed and dropped (cancel_cnt--), then FSM issues REQ to new fetch_pc.
//  Redirect in REQ without addr_ok: inst_addr switches to target next cycle; no cancel.
//  cancel_cnt is 2 bits, saturates at 3 (bus allows <=1 outstanding so 1 is the max used).
//  Simultaneous data_ok and redirect: data dropped, redirect wins.
//  Misaligned fetch_pc[1:0]!=0: no bus request; slot <= {excepttype[16]=1 (AdEL-IF), ce=1,
//   pc=fetch_pc, inst=0}; FSM stays IDLE until a flush redirects.
//  rst mid-transaction: all state cleared; a late data_ok after reset is ignored (cancel_cnt=0,
//   state=IDLE => data_ok outside WAIT is discarded).
//  excepttype bits other than [16] always 0 from this stage.
// STRUCTURE
//  Shared defines header (lib/defines.vh): IC_TO_ID_WD, `StallBus, `Stop/`NoStop,
//   EXC_ADEL_IF bit index (16), RESET_PC constant, fetch FSM state encodings.
//  One sub-module natural: ic_out_buf (1-entry holding register for ic_to_id_bus/ic_inst with
//   valid, load, hold and clear). FSM + PC + cancel counter stay in ic_fetch.
// TESTING
//  Reset then zero-wait bus (addr_ok same cycle, data_ok next) -> pcs BFC00000,04,08 with ce=1.
//  stall[1]=`Stop 3 cycles while slot valid -> bus outputs constant, inst_req=0, no pc skipped.
//  br_e, br_addr=0x80001000 while in WAIT for 0xBFC00008 -> returned word dropped, next ce=1 pc=0x80001000.
//  flush, new_pc=0xBFC00380, same cycle as data_ok -> data dropped; first presented pc=0xBFC00380.
//  flush to new_pc=0x80000002 -> no inst_req; slot excepttype=32'h0001_0000, ce=1, inst=0.
//  rst asserted in WAIT, late data_ok next cycle -> ignored; first fetch RESET_PC, stallreq=1 until valid.

Source files
------------

// File: rtl/ic_fetch_pkg.sv
// rtl/ic_fetch_pkg.sv - shared constants and types for the instruction-fetch stage
//
// Purpose: stall-bus encoding, exception bit index, reset PC, fetch FSM state
//   encodings and the packed layout of ic_to_id_bus.
// Ports: none (package).

package ic_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'hBFC0_0000;
  localparam int          IC_TO_ID_WD_DEFAULT = 65;

  localparam int   STALL_BUS_WD = 6;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  localparam int EXC_ADEL_IF = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  typedef struct packed {
    logic [31:0] excepttype;
    logic        ce;
    logic [31:0] pc;
  } ic_to_id_t;

  function automatic logic [31:0] adel_if_excepttype();
    logic [31:0] e;
    e              = '0;
    e[EXC_ADEL_IF] = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/ic_fetch_out_buf.sv
// rtl/ic_fetch_out_buf.sv - one-entry holding register for the fetch-to-decode slot
//
// Purpose: holds one {excepttype, ce, pc} + instruction word for decode.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clear_i      drop the held entry (redirect)
//   load_i       new entry offered on bus_d_i/inst_d_i
//   hold_i       decode is stalled; keep presenting the current entry
//   bus_d_i      entry to load
//   inst_d_i     instruction to load
//   valid_o      slot holds a real entry
//   bus_o        presented entry (all zero when empty)
//   inst_o       presented instruction (zero when empty)

module ic_fetch_out_buf
  import ic_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        hold_i,
  input  ic_to_id_t   bus_d_i,
  input  logic [31:0] inst_d_i,
  output logic        valid_o,
  output ic_to_id_t   bus_o,
  output logic [31:0] inst_o
);

  logic        valid_q;
  ic_to_id_t   bus_q;
  logic [31:0] inst_q;

  // An empty slot is stored as zeros so decode sees ce=0, pc=0 bubbles
  // directly from the register. A held valid entry is never overwritten.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
      inst_q  <= '0;
    end else if (load_i && (!valid_q || !hold_i)) begin
      valid_q <= 1'b1;
      bus_q   <= bus_d_i;
      inst_q  <= inst_d_i;
    end else if (!hold_i) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
      inst_q  <= '0;
    end
  end

  assign valid_o = valid_q;
  assign bus_o   = bus_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/ic_fetch.sv
// rtl/ic_fetch.sv - instruction-fetch stage: PC, SRAM-like request FSM, decode slot
//
// Purpose: owns the fetch PC, issues req/addr_ok/data_ok reads and presents
//   {excepttype, ce, pc} plus the fetched word to decode.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall[5:0]                    pipeline stall bus; stall[1]==STOP holds our output
//   flush, new_pc                 exception/eret redirect
//   br_e, br_addr                 taken branch redirect
//   stallreq                      decode would take a bubble
//   inst_req, inst_addr           request and word-aligned address
//   inst_addr_ok                  request accepted
//   inst_data_ok, inst_rdata      read data return
//   ic_to_id_bus, ic_inst         slot presented to decode

module ic_fetch
  import ic_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          IC_TO_ID_WD = IC_TO_ID_WD_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS_WD-1:0] stall,
  input  logic                    flush,
  input  logic [31:0]             new_pc,
  input  logic                    br_e,
  input  logic [31:0]             br_addr,
  output logic                    stallreq,
  output logic                    inst_req,
  output logic [31:0]             inst_addr,
  input  logic                    inst_addr_ok,
  input  logic                    inst_data_ok,
  input  logic [31:0]             inst_rdata,
  output logic [IC_TO_ID_WD-1:0]  ic_to_id_bus,
  output logic [31:0]             ic_inst
);

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [1:0]  cancel_q, cancel_d;
  logic        exc_sent_q, exc_sent_d;

  logic        consume;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misaligned;
  logic        slot_free;
  logic        addr_acc;
  logic        data_hit;
  logic        data_keep;
  logic        exc_load;
  logic        cancel_inc;

  logic        buf_valid;
  logic        buf_load;
  ic_to_id_t   buf_d;
  logic [31:0] buf_inst_d;
  ic_to_id_t   buf_q;
  logic [31:0] buf_inst_q;

  logic        unused_stall;
  assign unused_stall = ^{stall[STALL_BUS_WD-1:2], stall[0]};

  assign consume     = (stall[1] == NO_STOP);
  assign redirect    = flush | br_e;
  assign redirect_pc = flush ? new_pc : br_addr;
  assign misaligned  = (fetch_pc_q[1:0] != 2'b00);

  // A request is only issued into an empty slot (or one decode takes this
  // edge), so whenever a read is in flight the slot is empty and the returning
  // word can always be loaded.
  assign slot_free = !buf_valid || consume;

  assign inst_req  = (state_q == S_REQ) && !misaligned;
  assign inst_addr = {fetch_pc_q[31:2], 2'b00};
  assign addr_acc  = inst_req && inst_addr_ok;

  // data_ok outside WAIT (e.g. a beat that was in flight across reset) is ignored.
  assign data_hit  = (state_q == S_WAIT) && inst_data_ok;
  assign data_keep = data_hit && (cancel_q == 2'd0) && !redirect;

  // The address-error pseudo-instruction is presented once per bad PC.
  assign exc_load  = (state_q == S_IDLE) && misaligned && !exc_sent_q &&
                     slot_free && !redirect;

  // Only the single live read can be cancelled; a read already cancelled
  // is not counted again by a second redirect.
  assign cancel_inc = redirect &&
                      (addr_acc ||
                       ((state_q == S_WAIT) && (cancel_q == 2'd0) && !inst_data_ok));

  assign buf_load = data_keep || exc_load;

  always_comb begin
    buf_d      = '0;
    buf_inst_d = '0;
    if (data_keep) begin
      buf_d.excepttype = '0;
      buf_d.ce         = 1'b1;
      buf_d.pc         = pend_pc_q;
      buf_inst_d       = inst_rdata;
    end else begin
      buf_d.excepttype = adel_if_excepttype();
      buf_d.ce         = 1'b1;
      buf_d.pc         = fetch_pc_q;
      buf_inst_d       = '0;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (addr_acc) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_comb begin
    pend_pc_d = pend_pc_q;
    if (addr_acc) begin
      pend_pc_d = fetch_pc_q;
    end
  end

  always_comb begin
    cancel_d = cancel_q;
    if (data_hit && (cancel_q != 2'd0)) begin
      cancel_d = cancel_q - 2'd1;
    end else if (cancel_inc && (cancel_q != 2'd3)) begin
      cancel_d = cancel_q + 2'd1;
    end
  end

  always_comb begin
    exc_sent_d = exc_sent_q;
    if (redirect) begin
      exc_sent_d = 1'b0;
    end else if (exc_load) begin
      exc_sent_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // A redirect spends this cycle updating fetch_pc; the new target
        // is requested from IDLE next cycle with a cleared slot.
        if (!redirect && !misaligned && slot_free) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (addr_acc) begin
          state_d = S_WAIT;
        end else if (misaligned && !redirect) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      cancel_q   <= 2'd0;
      exc_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      cancel_q   <= cancel_d;
      exc_sent_q <= exc_sent_d;
    end
  end

  ic_fetch_out_buf u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (redirect),
    .load_i   (buf_load),
    .hold_i   (!consume),
    .bus_d_i  (buf_d),
    .inst_d_i (buf_inst_d),
    .valid_o  (buf_valid),
    .bus_o    (buf_q),
    .inst_o   (buf_inst_q)
  );

  assign ic_to_id_bus = IC_TO_ID_WD'(buf_q);
  assign ic_inst      = buf_inst_q;

  assign stallreq = ((state_q != S_IDLE) || !buf_valid) && !rst;

endmodule
